fetch_unit: RTL and testbench

Instruction fetch front end of the single-issue RISC-V core. It is the initiator on the cache instruction port: it drives the fetch address, captures the returned instruction word, and buffers it in a small queue. It presents instructions with their PCs to the decode/execute side over a valid/ready handshake, and it handles redirects (`jmp_en`/`jmp_addr`) and pipeline clears (`clr`) coming back from `exe`.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: XLEN, instruction size and the {pc, ins} fetch queue entry.
// Pure declarations, no latency or flow control of its own.
package cpu_pkg;
  localparam int XLEN      = 32;
  localparam int INS_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INS_BYTES);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: cache instruction port, exe redirect/clear, and the valid/ready output.
// The master side is the fetch unit; the slave side is the cache/exe/decode environment.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] ins_addr;
  logic [XLEN-1:0] ins;
  logic            jmp_en;
  logic [XLEN-1:0] jmp_addr;
  logic            clr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_ins;
  logic [XLEN-1:0] out_pc;

  modport master (
    output ins_addr, out_valid, out_ins, out_pc,
    input  ins, jmp_en, jmp_addr, clr, out_ready
  );

  modport slave (
    input  ins_addr, out_valid, out_ins, out_pc,
    output ins, jmp_en, jmp_addr, clr, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue of {pc, ins}; head visible combinationally, push/pop same cycle, flush clears.
// No internal backpressure: the caller must never push when full or pop when empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr] <= i_push_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap without compare logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: issues one fetch per cycle, 2-cycle fetch-to-output, 2 bubbles after a flush.
// Issue stalls whenever queued plus in-flight entries would exceed DEPTH, so responses never drop.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_commit_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  fetch_entry_t    r_hold;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;
  logic            w_out_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_flush;
  logic            w_issue;
  logic [XLEN-1:0] w_commit_next;
  logic [XLEN-1:0] w_jmp_tgt;

  assign w_out_valid   = (w_count != '0);
  assign w_pop         = w_out_valid && bus.out_ready;
  assign w_flush       = bus.jmp_en || bus.clr;
  assign w_push        = r_inflight && !w_flush;
  assign w_push_dat    = '{pc: r_inflight_pc, ins: bus.ins};
  assign w_commit_next = w_pop ? pc_next(r_commit_pc) : r_commit_pc;
  assign w_jmp_tgt     = bus.jmp_addr & ~XLEN'(INS_BYTES - 1);
  assign w_issue       = !w_flush &&
                         ((w_count + CW'(r_inflight) - CW'(w_pop)) < CW'(DEPTH));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  // A pop coinciding with a flush still retires: commit_pc advances before any replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_commit_pc   <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_hold        <= '0;
    end else begin
      if (bus.jmp_en) begin
        r_pc        <= w_jmp_tgt;
        r_commit_pc <= w_jmp_tgt;
        r_inflight  <= 1'b0;
      end else if (bus.clr) begin
        r_pc        <= w_commit_next;
        r_commit_pc <= w_commit_next;
        r_inflight  <= 1'b0;
      end else begin
        r_commit_pc <= w_commit_next;
        r_inflight  <= w_issue;
        if (w_issue) begin
          r_inflight_pc <= r_pc;
          r_pc          <= pc_next(r_pc);
        end
      end
      if (w_out_valid) r_hold <= w_head;
    end
  end

  assign bus.ins_addr  = r_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ins   = w_out_valid ? w_head.ins : r_hold.ins;
  assign bus.out_pc    = w_out_valid ? w_head.pc  : r_hold.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a random run against a stream model
// in which accepted PCs run sequentially and restart at the jump target (clr keeps the stream).
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Cache: word for the address issued last cycle.
  always @(posedge clk) bus.ins <= ins_of(bus.ins_addr);

  int          n_chk  = 0;
  int          n_fail = 0;
  int          stall  = 0;
  logic [31:0] exp_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at the negedge, score any acceptance, advance to the next negedge.
  task automatic step(input bit rdy, input bit jmp, input logic [31:0] ja, input bit cl);
    bus.out_ready = rdy;
    bus.jmp_en    = jmp;
    bus.jmp_addr  = ja;
    bus.clr       = cl;
    if (bus.out_valid && rdy) begin
      chk("acc_pc", bus.out_pc, exp_pc);
      chk("acc_ins", bus.out_ins, ins_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      stall  = 0;
    end else if (rdy) begin
      stall++;
    end
    if (jmp) begin
      exp_pc = ja & 32'hFFFF_FFFC;
      stall  = 0;
    end else if (cl) begin
      stall = 0;
    end
    if (stall > 4) begin
      chk("stall_bound", 32'(stall), 32'd0);
      stall = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.jmp_en    = 1'b0;
    bus.jmp_addr  = '0;
    bus.clr       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr", bus.ins_addr, 32'h0);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_ins", bus.out_ins, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    rst    = 1'b0;
    exp_pc = 32'h0;
    stall  = 0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.jmp_en    = 1'b0;
    bus.jmp_addr  = '0;
    bus.clr       = 1'b0;
    @(negedge clk);

    // Startup stream and latency.
    do_reset();
    chk("c0_addr", bus.ins_addr, 32'h0);
    chk("c0_vld", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("c1_addr", bus.ins_addr, 32'h4);
    chk("c1_vld", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("c2_addr", bus.ins_addr, 32'h8);
    chk("c2_vld", 32'(bus.out_valid), 32'd1);
    chk("c2_pc", bus.out_pc, 32'h0);
    step(1, 0, 0, 0);
    chk("c3_pc", bus.out_pc, 32'h4);
    step(1, 0, 0, 0);
    chk("c4_pc", bus.out_pc, 32'h8);
    step(1, 0, 0, 0);

    // Backpressure from cycle 2.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_addr_hold", bus.ins_addr, 32'h8);
      chk("bp_head", bus.out_pc, 32'h0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_pc", bus.out_pc, 32'(i * 4));
      step(1, 0, 0, 0);
    end

    // Jump in cycle 5 with a coincident pop of 0xC.
    do_reset();
    repeat (5) step(1, 0, 0, 0);
    chk("jmp_pop_pc", bus.out_pc, 32'hC);
    step(1, 1, 32'h100, 0);
    chk("jmp_n1_vld", 32'(bus.out_valid), 32'd0);
    chk("jmp_n1_addr", bus.ins_addr, 32'h100);
    step(1, 0, 0, 0);
    chk("jmp_n2_vld", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("jmp_n3_vld", 32'(bus.out_valid), 32'd1);
    chk("jmp_n3_pc", bus.out_pc, 32'h100);
    step(1, 0, 0, 0);
    chk("jmp_n4_pc", bus.out_pc, 32'h104);
    step(1, 0, 0, 0);

    // Clear with 0xC/0x10 queued after 0x8 was accepted.
    do_reset();
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("clr_head", bus.out_pc, 32'hC);
    step(0, 0, 0, 1);
    chk("clr_n1_addr", bus.ins_addr, 32'hC);
    chk("clr_n1_vld", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("clr_n2_vld", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("clr_n3_pc", bus.out_pc, 32'hC);
    step(1, 0, 0, 0);
    chk("clr_n4_pc", bus.out_pc, 32'h10);
    step(1, 0, 0, 0);

    // Jump and clear together: jump wins.
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 32'h200, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("jc_pc", bus.out_pc, 32'h200);
    step(1, 0, 0, 0);

    // Address wrap, with unaligned target bits discarded.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFE, 0);
    chk("wrap_addr0", bus.ins_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap_addr1", bus.ins_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap_pc1", bus.out_pc, 32'h0);

    // Asynchronous reset mid-stream, between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(bus.out_valid), 32'd0);
    chk("arst_addr", bus.ins_addr, 32'h0);
    chk("arst_pc", bus.out_pc, 32'h0);
    @(negedge clk);

    // Random traffic against the stream model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit rdy;
      r   = int'($urandom_range(0, 39));
      rdy = ($urandom_range(0, 3) != 0);
      step(rdy, (r == 0) || (r == 3), $urandom, (r == 1) || (r == 2) || (r == 3));
    end
    repeat (6) step(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
